// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage array for sync_fifo.
//   clk      rising-edge clock
//   wr_en    write strobe; stores wr_data at wr_addr
//   wr_addr  write address
//   wr_data  write word
//   rd_en    read strobe; loads mem[rd_addr] into rd_data
//   rd_addr  read address
//   rd_data  registered read word, holds when rd_en is low
// The array and the read register are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // A same-edge read and write of one address returns the old word,
  // which is what a full FIFO doing read+write needs.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-in first-out buffer with registered read.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_en      write request; accepted when not full or when reading too
//   wr_data    word stored on an accepted write
//   rd_en      read request; accepted when not empty
//   rd_data    word from the last accepted read (0 after reset)
//   full       count == DEPTH
//   empty      count == 0
//   count      stored words, 0..DEPTH
//   overflow   one-cycle pulse after a rejected write
//   underflow  one-cycle pulse after a rejected read
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic             rd_zero;
  logic [WIDTH-1:0] mem_rd_data;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // When full, a simultaneous read frees the slot being written.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_zero   <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_zero <= 1'b0;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_en && full && !rd_en;
      underflow <= rd_en && empty;
    end
  end

  // The storage read register has no reset; rd_zero forces the visible
  // word to 0 from reset until the first accepted read reloads it.
  assign rd_data = rd_zero ? '0 : mem_rd_data;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc && !rst),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc && !rst),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             overflow;
  logic             underflow;

  always #5 clk = ~clk;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    int         step;
    logic [7:0] rd;
    int         cnt;
    bit         full;
    bit         empty;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       sb[$];
  byte unsigned model_q[$];
  logic [7:0] model_rd = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         step_no = 0;
  exp_t       mon_e;

  function automatic void chk(string name, int stp, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, stp, got, exp);
    end
  endfunction

  // Reference model: a plain queue of words; expectation is pushed before
  // the edge, the monitor compares after it.
  task automatic step(input bit r_st, input bit w, input logic [7:0] d, input bit r);
    exp_t e;
    bit   m_full, m_empty, ovf, unf;
    rst     = r_st;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    ovf = 1'b0;
    unf = 1'b0;
    if (r_st) begin
      model_q.delete();
      model_rd = 8'h00;
    end else begin
      m_full  = (model_q.size() == DEPTH);
      m_empty = (model_q.size() == 0);
      if (r && !m_empty) model_rd = model_q.pop_front();
      if (w && (!m_full || r)) model_q.push_back(d);
      ovf = w && m_full && !r;
      unf = r && m_empty;
    end
    e.step  = step_no;
    e.rd    = model_rd;
    e.cnt   = model_q.size();
    e.full  = (model_q.size() == DEPTH);
    e.empty = (model_q.size() == 0);
    e.ovf   = ovf;
    e.unf   = unf;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: outputs are registered, so every edge presents a new result.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("rd_data",   mon_e.step, 32'(rd_data),   32'(mon_e.rd));
      chk("count",     mon_e.step, 32'(count),     32'(mon_e.cnt));
      chk("full",      mon_e.step, 32'(full),      32'(mon_e.full));
      chk("empty",     mon_e.step, 32'(empty),     32'(mon_e.empty));
      chk("overflow",  mon_e.step, 32'(overflow),  32'(mon_e.ovf));
      chk("underflow", mon_e.step, 32'(underflow), 32'(mon_e.unf));
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

    // reset then idle
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle(); idle();

    // fill, overflow, drain
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b1, 8'h44, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // underflow on empty
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // full with simultaneous read+write
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
    step(1'b0, 1'b1, 8'hB0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // empty with simultaneous read+write
    step(1'b0, 1'b1, 8'hC5, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // reset mid-operation, with a write pending
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // randomized traffic in phases of varying write/read bias
    for (int ph = 0; ph < 12; ph++) begin
      int unsigned wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 50; i++) begin
        step(($urandom_range(0, 99) < 2),
             ($urandom_range(0, 99) < wp),
             8'($urandom),
             ($urandom_range(0, 99) < rp));
      end
    end
    idle();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #5;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
